// File: rtl/dsp_ctr_mc.sv
// dsp_ctr_mc -- multi-channel terminal counter.
//
// Each channel is armed by a load strobe. Once armed, it counts up from 0 to
// its captured end value on every enabled edge. Reaching the end value gives
// a one-cycle registered event. In auto-reload mode the channel then wraps
// to 0. In one-shot mode it holds the end value and disarms.
//
// Optional build macro: DSP_CTR_MC_CASCADE_EN
//   When defined, channel i>0 advances only on edges where channel i-1 hits
//   its terminal tick on that same edge. This chains the channels into a
//   wide prescaler. When undefined, every channel uses its own enable bit.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   enable     [NUM_CHANNELS]          per-channel count enable
//   load       [NUM_CHANNELS]          per-channel load/arm strobe
//   end_val    [NUM_CHANNELS*W]        terminal values, channel i at [i*W +: W]
//   oneshot    [NUM_CHANNELS]          mode captured on load (1 = one-shot)
//   ctr_val    [NUM_CHANNELS*W]        registered counts, same packing
//   ctr_event  [NUM_CHANNELS]          registered terminal-count pulse
//   active     [NUM_CHANNELS]          channel armed (RUN state)

module dsp_ctr_mc_ch #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,       // effective enable
    input  logic         i_load,
    input  logic         i_oneshot,
    input  logic         i_term,     // terminal tick, computed by the parent
    input  logic [W-1:0] i_end_val,
    output logic [W-1:0] o_cnt,
    output logic [W-1:0] o_end,
    output logic         o_event,
    output logic         o_active
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t       r_state, w_state_nxt;
    logic [W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0] r_end, w_end_nxt;
    logic         r_mode, w_mode_nxt;
    logic         r_evt, w_evt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_end   <= '0;
            r_mode  <= 1'b0;
            r_evt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_end   <= w_end_nxt;
            r_mode  <= w_mode_nxt;
            r_evt   <= w_evt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_end_nxt   = r_end;
        w_mode_nxt  = r_mode;
        w_evt_nxt   = 1'b0;
        if (i_load) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_end_nxt   = i_end_val;
            w_mode_nxt  = i_oneshot;
        end else if (i_term) begin
            // i_term already implies RUN, enabled and count == end.
            w_evt_nxt = 1'b1;
            if (r_mode) w_state_nxt = S_IDLE;   // one-shot: hold at end
            else        w_cnt_nxt   = '0;       // auto-reload: wrap
        end else if (r_state == S_RUN && i_en) begin
            // The count is below end here, so the increment cannot overflow.
            w_cnt_nxt = r_cnt + W'(1);
        end
    end

    assign o_cnt    = r_cnt;
    assign o_end    = r_end;
    assign o_event  = r_evt;
    assign o_active = (r_state == S_RUN);
endmodule

module dsp_ctr_mc #(
    parameter int COUNTER_WIDTH = 8,
    parameter int NUM_CHANNELS  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CHANNELS-1:0]               enable,
    input  logic [NUM_CHANNELS-1:0]               load,
    input  logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] end_val,
    input  logic [NUM_CHANNELS-1:0]               oneshot,
    output logic [NUM_CHANNELS*COUNTER_WIDTH-1:0] ctr_val,
    output logic [NUM_CHANNELS-1:0]               ctr_event,
    output logic [NUM_CHANNELS-1:0]               active
);
    localparam int W = COUNTER_WIDTH;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic         w_en_eff;
        logic         w_term;
        logic [W-1:0] w_end_reg;

`ifdef DSP_CTR_MC_CASCADE_EN
        // Chain on the same-edge tick of the previous channel. Using the
        // registered event would lag by one cycle per stage.
        if (i == 0) begin : g_head
            assign w_en_eff = enable[i];
        end else begin : g_link
            assign w_en_eff = enable[i] & g_ch[i-1].w_term;
        end
`else
        assign w_en_eff = enable[i];
`endif

        // Terminal tick: armed, enabled, at end, and not overridden by a load.
        assign w_term = active[i] & w_en_eff & ~load[i] &
                        (ctr_val[i*W +: W] == w_end_reg);

        dsp_ctr_mc_ch #(.W(W)) u_ch (
            .i_clk     (clk),
            .i_rst     (rst),
            .i_en      (w_en_eff),
            .i_load    (load[i]),
            .i_oneshot (oneshot[i]),
            .i_term    (w_term),
            .i_end_val (end_val[i*W +: W]),
            .o_cnt     (ctr_val[i*W +: W]),
            .o_end     (w_end_reg),
            .o_event   (ctr_event[i]),
            .o_active  (active[i])
        );
    end
endmodule

// File: tb/tb_dsp_ctr_mc.sv
module tb_dsp_ctr_mc;
    localparam int W = 6;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   enable, load, oneshot;
    logic [N*W-1:0] end_val;
    logic [N*W-1:0] ctr_val;
    logic [N-1:0]   ctr_event, active;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: plain integers per channel.
    int m_cnt [N];
    int m_end [N];
    bit m_mode[N];
    bit m_act [N];
    bit m_evt [N];

    dsp_ctr_mc #(.COUNTER_WIDTH(W), .NUM_CHANNELS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .load      (load),
        .end_val   (end_val),
        .oneshot   (oneshot),
        .ctr_val   (ctr_val),
        .ctr_event (ctr_event),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d @%0t", tag, act, exp, $time);
        end
    endtask

    // Apply the counter rules for one clock edge, using the inputs present at it.
    task automatic model_edge();
        bit prev_tick = 1'b0;
        for (int i = 0; i < N; i++) begin
            bit en, tick;
            if (rst) begin
                m_cnt[i] = 0; m_end[i] = 0; m_mode[i] = 0; m_act[i] = 0; m_evt[i] = 0;
                continue;
            end
            en = enable[i];
`ifdef DSP_CTR_MC_CASCADE_EN
            if (i > 0) en = en & prev_tick;
`endif
            tick = !load[i] && m_act[i] && en && (m_cnt[i] == m_end[i]);
            m_evt[i] = tick;
            if (load[i]) begin
                m_cnt[i] = 0; m_end[i] = end_val[i*W +: W]; m_mode[i] = oneshot[i]; m_act[i] = 1;
            end else if (tick) begin
                if (m_mode[i]) m_act[i] = 0;
                else           m_cnt[i] = 0;
            end else if (m_act[i] && en) begin
                m_cnt[i] = m_cnt[i] + 1;
            end
            prev_tick = tick;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("ctr%0d", i), 32'(ctr_val[i*W +: W]), m_cnt[i]);
            chk($sformatf("evt%0d", i), 32'(ctr_event[i]), 32'(m_evt[i]));
            chk($sformatf("act%0d", i), 32'(active[i]), 32'(m_act[i]));
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    function automatic logic [31:0] cv(input int ch);
        return 32'(ctr_val[ch*W +: W]);
    endfunction

    task automatic do_load(input int ch, input int ev, input bit os);
        load[ch] = 1'b1;
        end_val[ch*W +: W] = W'(ev);
        oneshot[ch] = os;
        step();
        load[ch] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = '0; load = '0; oneshot = '0; end_val = '0;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_end[i] = 0; m_mode[i] = 0; m_act[i] = 0; m_evt[i] = 0;
        end
        steps(2);
        chk("rst_ctr", 32'(ctr_val), 0);
        chk("rst_evt", 32'(ctr_event), 0);
        chk("rst_act", 32'(active), 0);
        rst = 1'b0;

        // Loaded but never enabled: armed, stuck at 0, no event.
        do_load(0, 5, 1'b0);
        steps(5);
        chk("ld_noen_ctr0", cv(0), 0);
        chk("ld_noen_act0", 32'(active[0]), 1);
        chk("ld_noen_evt0", 32'(ctr_event[0]), 0);

        // Auto-reload with end 15: event period of 16 cycles.
        do_load(0, 15, 1'b0);
        enable = 4'b0001;
        steps(15);
        chk("ar_at15", cv(0), 15);
        chk("ar_at15_evt", 32'(ctr_event[0]), 0);
        step();
        chk("ar_wrap_ctr", cv(0), 0);
        chk("ar_wrap_evt", 32'(ctr_event[0]), 1);
        step();
        chk("ar_pulse_end", 32'(ctr_event[0]), 0);
        chk("ar_after_wrap", cv(0), 1);
        steps(15);
        chk("ar_second_evt", 32'(ctr_event[0]), 1);
        enable = '0;

`ifndef DSP_CTR_MC_CASCADE_EN
        // One-shot with end 3 on channel 1.
        do_load(1, 3, 1'b1);
        enable = 4'b0010;
        steps(3);
        chk("os_at3", cv(1), 3);
        step();
        chk("os_evt", 32'(ctr_event[1]), 1);
        chk("os_idle", 32'(active[1]), 0);
        chk("os_hold", cv(1), 3);
        steps(4);
        chk("os_still", cv(1), 3);
        chk("os_no_evt", 32'(ctr_event[1]), 0);

        // Reset mid-count on channel 2, then enable alone must not restart it.
        do_load(2, 20, 1'b0);
        enable = 4'b0100;
        steps(7);
        chk("mid_at7", cv(2), 7);
        rst = 1'b1; step(); rst = 1'b0;
        chk("mid_rst_ctr", 32'(ctr_val), 0);
        chk("mid_rst_act", 32'(active), 0);
        steps(3);
        chk("mid_no_restart", cv(2), 0);
        do_load(2, 20, 1'b0);
        step();
        chk("mid_reload", cv(2), 1);

        // Load wins over enable at count 9.
        steps(8);
        chk("ldpri_at9", cv(2), 9);
        do_load(2, 20, 1'b0);
        chk("ldpri_ctr", cv(2), 0);
        chk("ldpri_evt", 32'(ctr_event[2]), 0);

        // End value 0, auto-reload: event stays high while enabled.
        do_load(3, 0, 1'b0);
        enable = 4'b1000;
        steps(3);
        chk("e0_evt_hi", 32'(ctr_event[3]), 1);
        enable = '0;
        step();
        chk("e0_evt_lo", 32'(ctr_event[3]), 0);
`else
        // Cascade: ch0 end 3 prescales ch1 end 2.
        rst = 1'b1; step(); rst = 1'b0;
        load = 4'b0011; oneshot = '0;
        end_val[0*W +: W] = W'(3);
        end_val[1*W +: W] = W'(2);
        step();
        load = '0;
        enable = '1;
        steps(4);
        chk("cas_ch1_1", cv(1), 1);
        chk("cas_ch0_evt", 32'(ctr_event[0]), 1);
        steps(4);
        chk("cas_ch1_2", cv(1), 2);
        steps(4);
        chk("cas_ch1_wrap", cv(1), 0);
        chk("cas_ch1_evt", 32'(ctr_event[1]), 1);
        step();
        chk("cas_ch1_evt_lo", 32'(ctr_event[1]), 0);
        steps(11);
        chk("cas_ch1_evt2", 32'(ctr_event[1]), 1);
        enable = '0;
`endif

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < N; i++) begin
                load[i]    = ($urandom_range(0, 19) == 0);
                enable[i]  = ($urandom_range(0, 3) != 0);
                oneshot[i] = $urandom_range(0, 1) == 1;
                case ($urandom_range(0, 3))
                    0:       end_val[i*W +: W] = W'($urandom_range(0, 3));
                    1:       end_val[i*W +: W] = W'($urandom_range(0, 15));
                    2:       end_val[i*W +: W] = '1;
                    default: end_val[i*W +: W] = W'($urandom);
                endcase
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dsp_ctr_mc.md
DSP_CTR_MC -- requirements
Module: dsp_ctr_mc

Interface
- REQ-001 Parameter: COUNTER_WIDTH, default 8, bit width of each channel's count and end value (legal range 2..32).
- REQ-002 Parameter: NUM_CHANNELS, default 4, number of independent counter channels (legal range 1..16).
- REQ-003 Port: clk  input  1  rising-edge clock for all state.
- REQ-004 Port: rst  input  1  synchronous, active-high reset.
- REQ-005 Port: enable  input  NUM_CHANNELS  per-channel count enable.
- REQ-006 Port: load  input  NUM_CHANNELS  per-channel load strobe; arms the channel.
- REQ-007 Port: end_val  input  NUM_CHANNELS*COUNTER_WIDTH  terminal values, channel i in bits [i*W +: W].
- REQ-008 Port: oneshot  input  NUM_CHANNELS  per-channel mode sampled on load: 1 = one-shot, 0 = auto-reload.
- REQ-009 Port: ctr_val  output  NUM_CHANNELS*COUNTER_WIDTH  registered counts, same packing as end_val.
- REQ-010 Port: ctr_event  output  NUM_CHANNELS  registered one-cycle terminal-count pulse per channel.
- REQ-011 Port: active  output  NUM_CHANNELS  channel is armed and may count.

Function
- REQ-012 Each channel SHALL hold registers: count (W bits), end_reg (W bits), mode_reg (1 bit), active (1 bit), event (1 bit).
- REQ-013 A channel SHALL be in one of two states: IDLE (active=0) or RUN (active=1).
- REQ-014 load[i]=1 at an edge SHALL set count=0, end_reg=end_val[i], mode_reg=oneshot[i] and active=1, regardless of enable[i] or the current state.
- REQ-015 load SHALL have priority over counting: no increment and no event occur on a load edge.
- REQ-016 In IDLE, the count SHALL hold; enable is ignored.
- REQ-017 In RUN with the effective enable high and count != end_reg, the count SHALL increment by 1 per edge.
- REQ-018 In RUN with the effective enable high and count == end_reg (the terminal tick), ctr_event[i] SHALL be 1 for the following cycle only.
- REQ-019 On a terminal tick in auto-reload mode, the count SHALL return to 0 and the channel SHALL stay in RUN.
- REQ-020 On a terminal tick in one-shot mode, the count SHALL hold at end_reg and the channel SHALL go to IDLE.
- REQ-021 With the effective enable low in RUN, the count SHALL hold and no event SHALL be produced.
- REQ-022 end_reg=0 SHALL cause a terminal tick on every enabled edge: auto-reload gives a continuous event, one-shot gives a single event.
- REQ-023 The count SHALL never exceed end_reg, so no arithmetic overflow or wrap beyond end_reg occurs; end_reg = 2^W-1 is legal.
- REQ-024 Channels SHALL be fully independent except as defined in REQ-030.
- REQ-025 Outputs SHALL come directly from registers, with no combinational input-to-output paths.

Reset
- REQ-026 rst=1 at an edge SHALL clear count, end_reg, mode_reg, active and event in every channel to 0, overriding load and enable.
- REQ-027 A reset asserted mid-count SHALL abort the count; after reset, a channel SHALL NOT count until a new load.
- REQ-028 Reset values SHALL be ctr_val=0, ctr_event=0 and active=0 for all channels.

Configuration
- REQ-029 The macro DSP_CTR_MC_CASCADE_EN SHALL select cascade mode.
- REQ-030 With DSP_CTR_MC_CASCADE_EN defined: for i>0, the effective enable of channel i SHALL be enable[i] AND the same-edge terminal tick of channel i-1 (combinational, not the registered ctr_event); channel 0 uses enable[0].
- REQ-031 Without DSP_CTR_MC_CASCADE_EN: the effective enable of every channel SHALL be enable[i].

Verification (COUNTER_WIDTH=6, NUM_CHANNELS=4)
- REQ-032 Scenario: reset, then load[0] with enable=0 for 5 cycles -> ctr_val[0]=0, active[0]=1, no event.
- REQ-033 Scenario: load[0] with end_val=15, oneshot=0, enable held high -> 15 edges after load ctr_val=15; next edge ctr_val=0 and ctr_event[0]=1 for exactly 1 cycle; this repeats every 16 cycles.
- REQ-034 Scenario: load[1] with end_val=3, oneshot=1 -> count 0,1,2,3, event once, then holds at 3 with active[1]=0; further enables give no change.
- REQ-035 Scenario: rst at count 7 of channel 2 (end 20) -> all 0; enable alone does not restart; load restarts from 0.
- REQ-036 Scenario: load and enable on the same edge at count 9 -> count=0, no event; end_val=0 auto-reload -> ctr_event held high while enabled.
- REQ-037 Scenario (CASCADE_EN): ch0 end=3, ch1 end=2, both auto-reload, all enabled -> ch1 increments once per 4 cycles; ctr_event[1] pulses every 12 cycles.
